// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 device-side transmitter: one-hot FSM states,
// frame geometry, the break prefix byte and the frame builder.
package ps2_pkg;

   localparam logic [3:0] IDLE = 4'b0001;
   localparam logic [3:0] HIGH = 4'b0010;
   localparam logic [3:0] LOW  = 4'b0100;
   localparam logic [3:0] GAP  = 4'b1000;

   localparam int         PS2_FRAME_BITS = 11;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

   // Bit 0 goes on the wire first: start 0, d0..d7, odd parity, stop 1.
   function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_tx_tick.sv
// Phase counter for the PS/2 transmitter: counts enabled cycles and flags the
// N-th one, wrapping to 0 on that cycle so every phase starts from zero.
module ps2_tx_tick #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int         W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt;

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: serializes one byte per request onto
// ps2_clk/ps2_data. Optional F0 break prefix is enabled by PS2_TX_BREAK_EN.
//
// state | meaning
// IDLE  | lines high, tx_ready=1, waiting for tx_valid
// HIGH  | ps2_clk high for CLK_DIV cycles, ps2_data shows the current bit
// LOW   | ps2_clk low for CLK_DIV cycles, ps2_data held (receiver samples here)
// GAP   | both lines high for GAP_CYC cycles before the next frame
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV = 2500,
   parameter int GAP_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
`ifdef PS2_TX_BREAK_EN
   input  logic       tx_break,
`endif
   output logic       tx_ready,
   output logic       tx_done,
   output logic       ps2_clk,
   output logic       ps2_data
);

   localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

   logic [3:0]                state;
   logic [3:0]                bit_idx;
   logic [PS2_FRAME_BITS-1:0] frame;
   logic                      accept;
   logic                      hp_tc;
   logic                      gap_tc;
`ifdef PS2_TX_BREAK_EN
   logic                      prefix;
   logic [7:0]                hold_byte;
`endif

   assign accept = (state == IDLE) && tx_valid;

   ps2_tx_tick #(.N(CLK_DIV)) u_half (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .en   ((state == HIGH) || (state == LOW)),
      .tc   (hp_tc)
   );

   ps2_tx_tick #(.N(GAP_CYC)) u_gap (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .en   (state == GAP),
      .tc   (gap_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_idx   <= '0;
         frame     <= '1;
         ps2_clk   <= 1'b1;
         ps2_data  <= 1'b1;
         tx_ready  <= 1'b1;
         tx_done   <= 1'b0;
`ifdef PS2_TX_BREAK_EN
         prefix    <= 1'b0;
         hold_byte <= '0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  state    <= HIGH;
                  bit_idx  <= '0;
                  tx_ready <= 1'b0;
                  ps2_data <= 1'b0;
`ifdef PS2_TX_BREAK_EN
                  if (tx_break) begin
                     frame     <= ps2_frame(PS2_BREAK_CODE);
                     hold_byte <= tx_data;
                     prefix    <= 1'b1;
                  end else
`endif
                  frame <= ps2_frame(tx_data);
               end
            end
            HIGH: begin
               if (hp_tc) begin
                  state   <= LOW;
                  ps2_clk <= 1'b0;
               end
            end
            LOW: begin
               if (hp_tc) begin
                  ps2_clk <= 1'b1;
                  if (bit_idx == LAST_BIT) begin
                     state    <= GAP;
                     ps2_data <= 1'b1;
                  end else begin
                     // frame[0] is always the bit on the wire; shift the next one in
                     state    <= HIGH;
                     bit_idx  <= bit_idx + 4'd1;
                     frame    <= {1'b1, frame[PS2_FRAME_BITS-1:1]};
                     ps2_data <= frame[1];
                  end
               end
            end
            GAP: begin
               if (gap_tc) begin
`ifdef PS2_TX_BREAK_EN
                  if (prefix) begin
                     prefix   <= 1'b0;
                     frame    <= ps2_frame(hold_byte);
                     bit_idx  <= '0;
                     state    <= HIGH;
                     ps2_data <= 1'b0;
                  end else
`endif
                  begin
                     state    <= IDLE;
                     tx_ready <= 1'b1;
                     tx_done  <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tx_ready <= 1'b1;
               ps2_clk  <= 1'b1;
               ps2_data <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx (CLK_DIV=4, GAP_CYC=8): cycle-level
// reference model, a behavioural PS/2 receiver and directed corner cases.
module tb_ps2_kbd_tx;

   localparam int CLK_DIV   = 4;
   localparam int GAP_CYC   = 8;
   localparam int BIT_CYC   = 2 * CLK_DIV;
   localparam int FRAME_CYC = 11 * BIT_CYC;
   localparam int SLOT      = FRAME_CYC + GAP_CYC;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
`ifdef PS2_TX_BREAK_EN
   logic       tx_break = 1'b0;
`endif
   logic       tx_ready, tx_done, ps2_clk, ps2_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
`ifdef PS2_TX_BREAK_EN
      .tx_break (tx_break),
`endif
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- reference model: time since acceptance -> wire levels
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   bit          m_busy  = 1'b0;
   bit          m_done  = 1'b0;
   int          m_n     = 0;
   int          m_total = SLOT;
   logic [10:0] m_fr [2];
   logic [7:0]  exp_q [$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_n    <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (tx_valid) begin
               m_busy  <= 1'b1;
               m_n     <= 0;
               m_total <= SLOT;
               m_fr[0] <= frame_of(tx_data);
`ifdef PS2_TX_BREAK_EN
               if (tx_break) begin
                  m_total <= 2 * SLOT;
                  m_fr[0] <= frame_of(8'hF0);
                  m_fr[1] <= frame_of(tx_data);
                  exp_q.push_back(8'hF0);
               end
`endif
               exp_q.push_back(tx_data);
            end
         end else begin
            m_n <= m_n + 1;
            if (m_n + 1 == m_total) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
            end
         end
      end
   end

   // {ps2_clk, ps2_data, tx_ready, tx_done}
   function automatic logic [3:0] model_exp();
      int s, k;
      if (!m_busy) return {3'b111, m_done};
      s = m_n / SLOT;
      k = m_n % SLOT;
      if (k < FRAME_CYC)
         return {((k % BIT_CYC) < CLK_DIV), m_fr[s][k / BIT_CYC], 2'b00};
      return 4'b1100;
   endfunction

   always @(negedge clk) begin
      if (chk_en)
         check($sformatf("cycle%0d", cyc), {28'd0, ps2_clk, ps2_data, tx_ready, tx_done}, {28'd0, model_exp()});
   end

   // ---------------- behavioural receiver: sample data on ps2_clk falling edges
   int          rx_n = 0;
   logic [10:0] rx_sh = '0;
   logic [10:0] rx_last = '0;
   logic [7:0]  rx_q [$];
   bit          brk = 1'b0;

   always @(negedge ps2_clk or negedge rst) begin
      if (!rst) begin
         rx_n <= 0;
      end else begin
         rx_sh[rx_n] <= ps2_data;
         if (rx_n == 10) begin
            rx_n    <= 0;
            rx_last <= {ps2_data, rx_sh[9:0]};
            rx_q.push_back(rx_sh[8:1]);
            brk     <= (rx_sh[8:1] == 8'hF0);
         end else begin
            rx_n <= rx_n + 1;
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge)
   task automatic send(input logic [7:0] d, output int acc);
      acc = -1;
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (tx_ready) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      check("accepted", {31'd0, acc >= 0}, 32'd1);
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         if (tx_done) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      check("done_seen", {31'd0, at >= 0}, 32'd1);
   endtask

   typedef struct {
      logic [7:0]  d;
      logic [10:0] fr;
      logic        p;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int acc, at, a1, hi;
      bit seen;

      tbl[0] = '{d: 8'h1C, fr: 11'h438, p: 1'b0};
      tbl[1] = '{d: 8'h00, fr: 11'h600, p: 1'b1};
      tbl[2] = '{d: 8'hFF, fr: 11'h7FE, p: 1'b1};
      tbl[3] = '{d: 8'h01, fr: 11'h402, p: 1'b0};

      // 1. reset
      repeat (3) @(negedge clk);
      check("rst_clk",   {31'd0, ps2_clk},  32'd1);
      check("rst_data",  {31'd0, ps2_data}, 32'd1);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_done",  {31'd0, tx_done},  32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rel_clk",   {31'd0, ps2_clk},  32'd1);
      check("rel_data",  {31'd0, ps2_data}, 32'd1);
      check("rel_ready", {31'd0, tx_ready}, 32'd1);
      check("rel_done",  {31'd0, tx_done},  32'd0);
      chk_en = 1'b1;

      // 2/3. single bytes and parity corners
      for (int i = 0; i < 4; i++) begin
         rx_q.delete();
         send(tbl[i].d, acc);
         wait_done(200, at);
         check($sformatf("latency_%0h", tbl[i].d), at - acc, 32'd96);
         check($sformatf("frame_%0h", tbl[i].d), {21'd0, rx_last}, {21'd0, tbl[i].fr});
         check($sformatf("parity_%0h", tbl[i].d), {31'd0, rx_last[9]}, {31'd0, tbl[i].p});
         check($sformatf("rxcount_%0h", tbl[i].d), rx_q.size(), 32'd1);
         if (rx_q.size() > 0) check($sformatf("rxbyte_%0h", tbl[i].d), {24'd0, rx_q[0]}, {24'd0, tbl[i].d});
         @(negedge clk);
      end

      // 4. back-to-back with tx_valid held, then an ignored mid-frame pulse
      rx_q.delete();
      tx_data = 8'h1C;
      tx_valid = 1'b1;
      a1 = -1;
      for (int i = 0; i < 50; i++) begin
         if (tx_ready) begin
            a1 = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      tx_data = 8'h32;
      for (int i = 0; i < 200 && cyc < a1 + 87; i++) @(negedge clk);
      check("b2b_last_low", {31'd0, ps2_clk}, 32'd0);
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ps2_clk && ps2_data) hi++;
         else break;
      end
      check("b2b_high_run", hi, 32'd9);
      check("b2b_start_bit", {30'd0, ps2_clk, ps2_data}, 32'b10);
      check("b2b_spacing", cyc - a1, 32'd97);
      tx_valid = 1'b0;
      repeat (20) @(negedge clk);
      tx_data = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_done(200, at);
      repeat (120) @(negedge clk);
      check("b2b_rxcount", rx_q.size(), 32'd2);
      if (rx_q.size() == 2) begin
         check("b2b_byte0", {24'd0, rx_q[0]}, 32'h1C);
         check("b2b_byte1", {24'd0, rx_q[1]}, 32'h32);
      end

      // 5. reset during bit 4 LOW
      rx_q.delete();
      send(8'h1C, acc);
      for (int i = 0; i < 100 && cyc < acc + 37; i++) @(negedge clk);
      check("mid_low_phase", {31'd0, ps2_clk}, 32'd0);
      #2 rst = 1'b0;
      #1;
      check("arst_clk",   {31'd0, ps2_clk},  32'd1);
      check("arst_data",  {31'd0, ps2_data}, 32'd1);
      check("arst_ready", {31'd0, tx_ready}, 32'd1);
      check("arst_done",  {31'd0, tx_done},  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         seen |= tx_done;
      end
      check("arst_no_done", {31'd0, seen}, 32'd0);
      check("arst_no_byte", rx_q.size(), 32'd0);
      send(8'h1C, acc);
      wait_done(200, at);
      check("arst_resend_latency", at - acc, 32'd96);
      check("arst_resend_count", rx_q.size(), 32'd1);
      if (rx_q.size() > 0) check("arst_resend_byte", {24'd0, rx_q[0]}, 32'h1C);
      @(negedge clk);

`ifdef PS2_TX_BREAK_EN
      // 6. break prefix
      rx_q.delete();
      tx_break = 1'b1;
      send(8'h1C, acc);
      tx_break = 1'b0;
      wait_done(400, at);
      check("brk_latency", at - acc, 32'd192);
      check("brk_count", rx_q.size(), 32'd2);
      if (rx_q.size() == 2) begin
         check("brk_byte0", {24'd0, rx_q[0]}, 32'hF0);
         check("brk_byte1", {24'd0, rx_q[1]}, 32'h1C);
      end
      check("brk_make_state", {31'd0, brk}, 32'd0);
      @(negedge clk);
`endif

      // randomized traffic against the model
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < 1500; i++) begin
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         @(negedge clk);
      end
      tx_valid = 1'b0;
      repeat (SLOT + 20) @(negedge clk);
      check("rand_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check($sformatf("rand_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
PS/2 device-side transmitter. It serializes scan-code bytes onto ps2_clk/ps2_data exactly as a keyboard would. It is the counterpart of the host-side PS/2 receiver and make/break tracking logic. It is used as the stimulus source for keyboard-path simulation and as an on-chip loopback source for the keyboard display path.

Parameters:
CLK_DIV, 2500, system clocks per PS/2 half-period (high phase = low phase = CLK_DIV); legal range >= 2.
GAP_CYC, 5000, idle cycles (both lines high) after the stop bit before the next frame may start; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
tx_data  input  8  byte to send.
tx_valid  input  1  request; accepted when tx_valid && tx_ready at a rising edge.
tx_ready  output  1  high only in IDLE.
tx_done  output  1  one-cycle pulse when a transfer completes.
ps2_clk  output  1  PS/2 clock, idle high.
ps2_data  output  1  PS/2 data, idle high.

Behaviour:
- Reset (rst=0, asynchronous) forces the following, regardless of the clk edge:
  - state=IDLE, all counters 0;
  - ps2_clk=1, ps2_data=1, tx_ready=1, tx_done=0.
- Frame is 11 bits, LSB first: start 0, d0..d7, odd parity p = ~^tx_data, stop 1.
- All outputs are registered. One-hot states: IDLE, HIGH, LOW, GAP.
- IDLE:
  - lines high, tx_ready=1;
  - on acceptance, latch tx_data and p, set bit_idx=0, go to HIGH;
  - tx_data changes after acceptance have no effect.
- HIGH, CLK_DIV cycles:
  - ps2_clk=1; ps2_data = frame bit bit_idx, updated on the first HIGH cycle;
  - in the cycle after acceptance, ps2_data=0 (start bit).
  - After CLK_DIV cycles, go to LOW.
- LOW, CLK_DIV cycles:
  - ps2_clk=0, ps2_data held, so the receiver samples on the falling edge with CLK_DIV cycles of setup;
  - at the end: if bit_idx==10 go to GAP, else bit_idx+1 and go to HIGH.
- GAP, GAP_CYC cycles:
  - ps2_clk=1, ps2_data=1;
  - on the last GAP cycle, go to IDLE;
  - tx_done=1 in the first IDLE cycle, coincident with tx_ready returning to 1.
- Frame timing: acceptance edge to first IDLE cycle = 22*CLK_DIV + GAP_CYC cycles.
- Boundary conditions:
  - tx_valid while tx_ready=0 is ignored; no queuing.
  - tx_valid held high continuously gives back-to-back frames separated by exactly GAP_CYC idle cycles plus 1 IDLE cycle.
  - Reset mid-frame abandons the frame; lines return high immediately and no tx_done is issued.
  - Half-period counter width = $clog2(CLK_DIV); it wraps to 0 on every phase change.
  - Bit index is 4 bits, 0..10; values 11..15 are unreachable.

Optional Feature:
Macro PS2_TX_BREAK_EN.
- Defined:
  - adds input tx_break (1 bit), sampled at acceptance;
  - if tx_break=1, the block first sends a full frame of 0xF0, then GAP_CYC idle cycles, then the latched tx_data frame;
  - tx_ready stays 0 throughout, and a single tx_done pulses only after the second frame's GAP;
  - a one-bit prefix flag marks the pending F0 and is cleared by reset.
- Undefined: port absent; every accepted byte yields exactly one frame.

Decomposition:
- Shared package ps2_pkg:
  - one-hot state constants IDLE=4'b0001, HIGH=4'b0010, LOW=4'b0100, GAP=4'b1000;
  - PS2_FRAME_BITS=11;
  - PS2_BREAK_CODE=8'hF0.
- Sub-module ps2_tx_tick: half-period/gap counter with load and terminal-count outputs, reused for the CLK_DIV and GAP_CYC counts.
- The FSM, shift/bit selection and parity stay in ps2_kbd_tx.

Test Plan (bench CLK_DIV=4, GAP_CYC=8):
1. Reset check: hold rst=0 for 3 cycles -> ps2_clk=1, ps2_data=1, tx_ready=1, tx_done=0; release -> values unchanged.
2. Single byte: send 0x1C -> at falling edges, bits decode 0,0,0,1,1,1,0,0,0,0(parity),1; tx_done pulses exactly 96 cycles after acceptance; the bench receiver gets 0x1C.
3. Parity corners: send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0.
4. Back-to-back: tx_valid held high with 0x1C then 0x32 -> two frames; lines high for exactly 9 cycles between the last LOW of frame 1 and the start bit of frame 2; a tx_valid pulse mid-frame is ignored.
5. Reset mid-frame: assert rst=0 during bit 4 LOW -> ps2_clk=1 and ps2_data=1 without waiting for clk; no tx_done; the next send of 0x1C is clean.
6. PS2_TX_BREAK_EN: send 0x1C with tx_break=1 -> frames 0xF0 then 0x1C with an 8-cycle gap; one tx_done at cycle 192; a downstream make/break FSM returns to its make state.
